// File: rtl/rcl_pkg.sv
// Shared definitions for the multi-circle line/circle relation classifier:
// relation codes, evaluator latency and the input FSM state type.
package rcl_pkg;

   localparam logic [1:0] REL_NONE    = 2'd0;
   localparam logic [1:0] REL_TANGENT = 2'd1;
   localparam logic [1:0] REL_SECANT  = 2'd2;
   localparam logic [1:0] REL_DEGEN   = 2'd3;

   localparam int unsigned EVAL_LAT = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOAD = 1'b1
   } rcl_state_e;

   // Maps the P1-versus-P2 comparison onto a relation code.
   function automatic logic [1:0] rel_from_cmp(input logic gt, input logic eq);
      if (gt)
         return REL_SECANT;
      else if (eq)
         return REL_TANGENT;
      else
         return REL_NONE;
   endfunction

endpackage

// File: rtl/rcl_eval.sv
// Two-stage relation evaluator: stage 1 registers P1/P2, stage 2 the code.
// Optional feature macro: RCL_DEGEN_CHECK_EN (a=b=0 reports REL_DEGEN).
module rcl_eval
   import rcl_pkg::*;
#(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         v_i,
   input  logic         last_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] c_i,
   input  logic [W-1:0] m_i,
   input  logic [W-1:0] n_i,
   input  logic [W-1:0] k_i,
   output logic         v_o,
   output logic [1:0]   rel_o,
   output logic         last_o
);

   localparam int P1W = 3*W + 1;
   localparam int P2W = 4*W + 4;
   localparam int LW  = 2*W + 2;

   logic signed [W-1:0]     a_s, b_s, c_s, m_s, n_s;
   logic signed [2*W-1:0]   a2, b2;
   logic        [2*W-1:0]   sumsq;
   logic signed [LW-1:0]    lin;
   logic signed [P2W-1:0]   lin_x, sq;
   logic        [P1W-1:0]   p1_d, s1_p1_q;
   logic        [P2W-1:0]   p2_d, s1_p2_q;
   logic                    s1_v_q, s1_last_q;
   logic        [P2W-1:0]   p1_ext;
   logic        [1:0]       rel_d, rel_q;
   logic                    v_q, last_q;
`ifdef RCL_DEGEN_CHECK_EN
   logic                    s1_degen_q;
`endif

   always_comb begin
      a_s   = a_i;
      b_s   = b_i;
      c_s   = c_i;
      m_s   = m_i;
      n_s   = n_i;
      a2    = (2*W)'(a_s) * (2*W)'(a_s);
      b2    = (2*W)'(b_s) * (2*W)'(b_s);
      sumsq = $unsigned(a2) + $unsigned(b2);
      p1_d  = P1W'(k_i) * P1W'(sumsq);
      lin   = LW'(a_s) * LW'(m_s) + LW'(b_s) * LW'(n_s) + LW'(c_s);
      lin_x = P2W'(lin);
      sq    = lin_x * lin_x;
      p2_d  = $unsigned(sq);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q     <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_p1_q    <= '0;
         s1_p2_q    <= '0;
`ifdef RCL_DEGEN_CHECK_EN
         s1_degen_q <= 1'b0;
`endif
      end else begin
         s1_v_q     <= v_i;
         s1_last_q  <= v_i & last_i;
         s1_p1_q    <= p1_d;
         s1_p2_q    <= p2_d;
`ifdef RCL_DEGEN_CHECK_EN
         s1_degen_q <= (a_i == '0) && (b_i == '0);
`endif
      end
   end

   always_comb begin
      p1_ext = P2W'(s1_p1_q);
      rel_d  = REL_NONE;
      if (s1_v_q) begin
         rel_d = rel_from_cmp(p1_ext > s1_p2_q, p1_ext == s1_p2_q);
`ifdef RCL_DEGEN_CHECK_EN
         if (s1_degen_q)
            rel_d = REL_DEGEN;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q    <= 1'b0;
         rel_q  <= REL_NONE;
         last_q <= 1'b0;
      end else begin
         v_q    <= s1_v_q;
         rel_q  <= rel_d;
         last_q <= s1_v_q & s1_last_q;
      end
   end

   assign v_o    = v_q;
   assign rel_o  = rel_q;
   assign last_o = last_q;

endmodule

// File: rtl/rcl_multi.sv
// Line/circle relation classifier for NUM_CIRC circles per line: input
// counter, FSM, operand latches and per-circle issue into rcl_eval.
// Optional feature macro (handled in rcl_eval): RCL_DEGEN_CHECK_EN.
module rcl_multi
   import rcl_pkg::*;
#(
   parameter int W        = 5,
   parameter int NUM_CIRC = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] coef_L,
   input  logic [W-1:0] coef_Q,
   output logic         out_valid,
   output logic [1:0]   out,
   output logic         out_last
);

   localparam int CNT_MAX = 3*NUM_CIRC - 1;
   localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

   rcl_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    ph_q, ph_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d, c_q, c_d, m_q, m_d, n_q, n_d;
   logic          iss_v_q, iss_v_d, iss_last_q, iss_last_d;
   logic [W-1:0]  iss_a_q, iss_a_d, iss_b_q, iss_b_d, iss_c_q, iss_c_d;
   logic [W-1:0]  iss_m_q, iss_m_d, iss_n_q, iss_n_d, iss_k_q, iss_k_d;
   logic          wrap;

   assign wrap = (cnt_q == CW'(CNT_MAX));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ph_d       = ph_q;
      a_d        = a_q;
      b_d        = b_q;
      c_d        = c_q;
      m_d        = m_q;
      n_d        = n_q;
      iss_v_d    = 1'b0;
      iss_last_d = 1'b0;
      iss_a_d    = iss_a_q;
      iss_b_d    = iss_b_q;
      iss_c_d    = iss_c_q;
      iss_m_d    = iss_m_q;
      iss_n_d    = iss_n_q;
      iss_k_d    = iss_k_q;

      // Wrap with in_valid high keeps LOAD; a drop either ends or aborts.
      case (state_q)
         ST_IDLE: if (in_valid)  state_d = ST_LOAD;
         ST_LOAD: if (!in_valid) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (in_valid) begin
         if (cnt_q == CW'(0)) a_d = coef_L;
         if (cnt_q == CW'(1)) b_d = coef_L;
         if (cnt_q == CW'(2)) c_d = coef_L;

         case (ph_q)
            2'd0: m_d = coef_Q;
            2'd1: n_d = coef_Q;
            default: begin
               // Circle 0 issues in the same cycle c arrives, so bypass c_q.
               iss_v_d    = 1'b1;
               iss_last_d = wrap;
               iss_a_d    = a_q;
               iss_b_d    = b_q;
               iss_c_d    = (cnt_q == CW'(2)) ? coef_L : c_q;
               iss_m_d    = m_q;
               iss_n_d    = n_q;
               iss_k_d    = coef_Q;
            end
         endcase

         cnt_d = wrap ? '0 : cnt_q + CW'(1);
         ph_d  = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
      end else begin
         cnt_d = '0;
         ph_d  = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         ph_q       <= 2'd0;
         a_q        <= '0;
         b_q        <= '0;
         c_q        <= '0;
         m_q        <= '0;
         n_q        <= '0;
         iss_v_q    <= 1'b0;
         iss_last_q <= 1'b0;
         iss_a_q    <= '0;
         iss_b_q    <= '0;
         iss_c_q    <= '0;
         iss_m_q    <= '0;
         iss_n_q    <= '0;
         iss_k_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ph_q       <= ph_d;
         a_q        <= a_d;
         b_q        <= b_d;
         c_q        <= c_d;
         m_q        <= m_d;
         n_q        <= n_d;
         iss_v_q    <= iss_v_d;
         iss_last_q <= iss_last_d;
         iss_a_q    <= iss_a_d;
         iss_b_q    <= iss_b_d;
         iss_c_q    <= iss_c_d;
         iss_m_q    <= iss_m_d;
         iss_n_q    <= iss_n_d;
         iss_k_q    <= iss_k_d;
      end
   end

   rcl_eval #(
      .W (W)
   ) u_eval (
      .clk    (clk),
      .rst_n  (rst_n),
      .v_i    (iss_v_q),
      .last_i (iss_last_q),
      .a_i    (iss_a_q),
      .b_i    (iss_b_q),
      .c_i    (iss_c_q),
      .m_i    (iss_m_q),
      .n_i    (iss_n_q),
      .k_i    (iss_k_q),
      .v_o    (out_valid),
      .rel_o  (out),
      .last_o (out_last)
   );

endmodule

// File: tb/tb_rcl_multi.sv
// Scoreboard bench for rcl_multi: one NUM_CIRC=1 and one NUM_CIRC=4 instance.
module tb_rcl_multi;

   localparam int W = 5;

   typedef struct {
      logic [1:0] code;
      logic       last;
      int         cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         iv1 = 1'b0, iv4 = 1'b0;
   logic [W-1:0] cl1 = '0, cq1 = '0, cl4 = '0, cq4 = '0;
   logic         ov1, ol1, ov4, ol4;
   logic [1:0]   o1, o4;

   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t q1[$];
   exp_t q4[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rcl_multi #(.W(W), .NUM_CIRC(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .coef_L(cl1), .coef_Q(cq1),
      .out_valid(ov1), .out(o1), .out_last(ol1));

   rcl_multi #(.W(W), .NUM_CIRC(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .coef_L(cl4), .coef_Q(cq4),
      .out_valid(ov4), .out(o4), .out_last(ol4));

   // Reference relation from the defining inequality on full-width integers.
   function automatic logic [1:0] ref_code(input int a, b, c, m, n, k);
      longint p1, l, p2;
      p1 = longint'(k) * longint'(a*a + b*b);
      l  = longint'(a*m + b*n + c);
      p2 = l * l;
`ifdef RCL_DEGEN_CHECK_EN
      if (a == 0 && b == 0) return 2'd3;
`endif
      if (p1 > p2)  return 2'd2;
      if (p1 == p2) return 2'd1;
      return 2'd0;
   endfunction

   function automatic int rnd_s();
      return int'($urandom_range(31)) - 16;
   endfunction

   // Output monitors: pop on every out_valid, otherwise outputs must be idle.
   always @(negedge clk) begin
      exp_t e;
      if (ov1 === 1'b1) begin
         vectors++;
         if (q1.size() == 0) begin
            miscompares++;
            $display("FAIL dut1_unexpected: out=%0d last=%0d cyc=%0d, required no out_valid", o1, ol1, cyc);
         end else begin
            e = q1.pop_front();
            if (o1 !== e.code || ol1 !== e.last || cyc !== e.cyc) begin
               miscompares++;
               $display("FAIL dut1_result: out=%0d last=%0d cyc=%0d, required out=%0d last=%0d cyc=%0d",
                        o1, ol1, cyc, e.code, e.last, e.cyc);
            end
         end
      end else if (ov1 !== 1'b0 || o1 !== 2'd0 || ol1 !== 1'b0) begin
         vectors++;
         miscompares++;
         $display("FAIL dut1_idle: valid=%b out=%0d last=%b, required 0/0/0", ov1, o1, ol1);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (ov4 === 1'b1) begin
         vectors++;
         if (q4.size() == 0) begin
            miscompares++;
            $display("FAIL dut4_unexpected: out=%0d last=%0d cyc=%0d, required no out_valid", o4, ol4, cyc);
         end else begin
            e = q4.pop_front();
            if (o4 !== e.code || ol4 !== e.last || cyc !== e.cyc) begin
               miscompares++;
               $display("FAIL dut4_result: out=%0d last=%0d cyc=%0d, required out=%0d last=%0d cyc=%0d",
                        o4, ol4, cyc, e.code, e.last, e.cyc);
            end
         end
      end else if (ov4 !== 1'b0 || o4 !== 2'd0 || ol4 !== 1'b0) begin
         vectors++;
         miscompares++;
         $display("FAIL dut4_idle: valid=%b out=%0d last=%b, required 0/0/0", ov4, o4, ol4);
      end
   end

   // Inputs driven at a negedge are sampled at the next posedge; the result
   // shows at the negedge two posedges after that.
   task automatic send1(input int a, b, c, m, n, k, input bit push);
      exp_t e;
      @(negedge clk); iv1 = 1'b1; cl1 = W'(a); cq1 = W'(m);
      @(negedge clk); cl1 = W'(b); cq1 = W'(n);
      @(negedge clk); cl1 = W'(c); cq1 = W'(k);
      if (push) begin
         e.code = ref_code(a, b, c, m, n, k);
         e.last = 1'b1;
         e.cyc  = cyc + 3;
         q1.push_back(e);
      end
   endtask

   task automatic drive4(input int a, b, c, input int ms[4], ns[4], ks[4], input int ncyc);
      exp_t e;
      int   line[3];
      line = '{a, b, c};
      for (int j = 0; j < ncyc; j++) begin
         @(negedge clk);
         iv4 = 1'b1;
         cl4 = (j < 3) ? W'(line[j]) : W'($urandom);
         case (j % 3)
            0: cq4 = W'(ms[j/3]);
            1: cq4 = W'(ns[j/3]);
            default: begin
               cq4    = W'(ks[j/3]);
               e.code = ref_code(a, b, c, ms[j/3], ns[j/3], ks[j/3]);
               e.last = (j/3 == 3);
               e.cyc  = cyc + 3;
               q4.push_back(e);
            end
         endcase
      end
   endtask

   task automatic idle_inputs();
      @(negedge clk);
      iv1 = 1'b0; iv4 = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((q1.size() != 0 || q4.size() != 0) && n < 30) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (q1.size() != 0 || q4.size() != 0) begin
         miscompares++;
         $display("FAIL %s_drain: pending dut1=%0d dut4=%0d, required 0/0", name, q1.size(), q4.size());
         q1.delete();
         q4.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if ({ov1, o1, ol1, ov4, o4, ol4} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: %b, required all zero", {ov1, o1, ol1, ov4, o4, ol4});
         end
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      send1(1, 0, 0, 3, 0, 9, 1'b1);
      send1(1, 0, 0, 3, 0, 10, 1'b1);
      send1(1, 0, 0, 3, 0, 4, 1'b1);
      idle_inputs();
      drain("single");
   endtask

   task automatic test_extremes();
      int ms[4], ns[4], ks[4];
      ms = '{15, -16, 15, 0};
      ns = '{15, -16, -16, 0};
      ks = '{31, 31, 0, 31};
      send1(-16, -16, -16, 15, 15, 31, 1'b1);
      idle_inputs();
      drive4(-16, -16, -16, ms, ns, ks, 12);
      idle_inputs();
      drain("extremes");
   endtask

   task automatic test_back_to_back();
      int ms[4], ns[4], ks[4];
      ms = '{5, 0, 1, -3};
      ns = '{0, 5, 1, 2};
      ks = '{9, 16, 0, 31};
      drive4(3, 4, 0, ms, ns, ks, 12);
      for (int i = 0; i < 4; i++) begin
         ms[i] = rnd_s();
         ns[i] = rnd_s();
         ks[i] = int'($urandom_range(31));
      end
      drive4(rnd_s(), rnd_s(), rnd_s(), ms, ns, ks, 12);
      idle_inputs();
      drain("back_to_back");
   endtask

   task automatic test_abort();
      int ms[4], ns[4], ks[4];
      ms = '{2, 7, 7, 7};
      ns = '{1, 7, 7, 7};
      ks = '{5, 7, 7, 7};
      drive4(1, 2, -4, ms, ns, ks, 5);
      idle_inputs();
      drain("abort");
      ms = '{1, -2, 4, 0};
      ns = '{1, 3, -1, 0};
      ks = '{2, 8, 20, 1};
      drive4(2, -1, 1, ms, ns, ks, 12);
      idle_inputs();
      drain("abort_restart");
   endtask

   task automatic test_reset_mid();
      send1(1, 0, 0, 3, 0, 10, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      iv1 = 1'b0;
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if ({ov1, o1, ol1} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: %b, required 0000", {ov1, o1, ol1});
         end
      end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      send1(1, 0, 0, 3, 0, 9, 1'b1);
      idle_inputs();
      drain("reset_mid");
   endtask

   task automatic test_degen();
      int ms[4], ns[4], ks[4];
      ms = '{3, -5, 0, 15};
      ns = '{2, 1, 0, -16};
      ks = '{7, 0, 31, 4};
      send1(0, 0, 0, 3, 2, 7, 1'b1);
      send1(0, 0, 5, 3, 2, 7, 1'b1);
      idle_inputs();
      drive4(0, 0, 0, ms, ns, ks, 12);
      drive4(0, 0, 5, ms, ns, ks, 12);
      idle_inputs();
      drain("degen");
   endtask

   initial begin
      test_reset();
      test_single();
      test_extremes();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_degen();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
